pipe_stage_reg: RTL and testbench

//  Parametrised Y86 pipeline-stage register, successor of the fixed F->D register.
//  - One instance per stage boundary (F/D, D/E, E/M, M/W).
//  - Loads, holds (stall) or injects a NOP bubble.
//  - Adds defined bubble/reset values, a valid flag and a stall-watchdog FSM that flags stuck stalls.

---
 rtl/pipe_stage_reg_if.sv | 33 +++
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 tb/tb_pipe_stage_reg.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream bus and control of one pipeline-stage register
interface pipe_stage_reg_if #(
  parameter int WORD_W = 64,
  parameter int STAT_W = 3
);
  logic              stall;
  logic              bubble;
  logic              clr_err;
  logic [STAT_W-1:0] in_stat;
  logic [3:0]        in_icode;
  logic [3:0]        in_ifun;
  logic [3:0]        in_rA;
  logic [3:0]        in_rB;
  logic [WORD_W-1:0] in_valC;
  logic [WORD_W-1:0] in_valP;
  logic [STAT_W-1:0] out_stat;
  logic [3:0]        out_icode;
  logic [3:0]        out_ifun;
  logic [3:0]        out_rA;
  logic [3:0]        out_rB;
  logic [WORD_W-1:0] out_valC;
  logic [WORD_W-1:0] out_valP;
  logic              out_valid;
  logic              stall_err;
  modport master (
    output stall, bubble, clr_err, in_stat, in_icode, in_ifun, in_rA, in_rB, in_valC, in_valP,
    input  out_stat, out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP, out_valid, stall_err
  );
  modport slave (
    input  stall, bubble, clr_err, in_stat, in_icode, in_ifun, in_rA, in_rB, in_valC, in_valP,
    output out_stat, out_icode, out_ifun, out_rA, out_rB, out_valC, out_valP, out_valid, stall_err
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: Y86 stage register with load/stall/bubble, valid flag and stall watchdog; PERF_CNT_EN adds stall/bubble counters
module pipe_stage_reg #(
  parameter int                WORD_W      = 64,
  parameter int                STAT_W      = 3,
  parameter logic [3:0]        NOP_ICODE   = 4'h1,
  parameter logic [3:0]        RNONE       = 4'hF,
  parameter logic [STAT_W-1:0] BUB_STAT    = STAT_W'(1),
  parameter int                STALL_LIMIT = 16,
  parameter int                CNT_W       = 16
) (
  input logic             clk,
  input logic             rst_n,
  pipe_stage_reg_if.slave bus
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);
  typedef struct packed {
    logic [STAT_W-1:0] stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [WORD_W-1:0] valc;
    logic [WORD_W-1:0] valp;
    logic              valid;
  } stage_t;
  typedef enum logic [1:0] {RUN, HOLD, ERR} state_t;
  localparam stage_t BUB = '{stat: BUB_STAT, icode: NOP_ICODE, ifun: 4'h0, ra: RNONE, rb: RNONE,
                             valc: '0, valp: '0, valid: 1'b0};
  stage_t pipe_q, pipe_d, in_w;
  state_t state_q, state_d;
  logic [CNT_W-1:0] rc_q, rc_d, rc_inc;
  logic hold_req;
  assign in_w = {bus.in_stat, bus.in_icode, bus.in_ifun, bus.in_rA, bus.in_rB, bus.in_valC, bus.in_valP, 1'b1};
  assign hold_req = bus.stall & ~bus.bubble;
  assign rc_inc = &rc_q ? rc_q : rc_q + 1'b1;
  // datapath next value: bubble beats stall beats load
  always_comb pipe_d = bus.bubble ? BUB : bus.stall ? pipe_q : in_w;
  // watchdog next state; ERR leaves only on clr_err and then behaves like RUN
  always_comb begin
    state_d = state_q;
    rc_d = rc_q;
    case (state_q)
      RUN: begin
        state_d = hold_req ? HOLD : RUN;
        rc_d = hold_req ? CNT_W'(1) : '0;
      end
      HOLD: begin
        state_d = !hold_req ? RUN : (rc_inc == CNT_W'(STALL_LIMIT)) ? ERR : HOLD;
        rc_d = hold_req ? rc_inc : '0;
      end
      ERR: if (bus.clr_err) begin
        state_d = hold_req ? HOLD : RUN;
        rc_d = hold_req ? CNT_W'(1) : '0;
      end
      default: begin
        state_d = RUN;
        rc_d = '0;
      end
    endcase
  end
  // stage contents and watchdog state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= BUB;
      state_q <= RUN;
      rc_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      state_q <= state_d;
      rc_q <= rc_d;
    end
  end
  assign bus.out_stat = pipe_q.stat;
  assign bus.out_icode = pipe_q.icode;
  assign bus.out_ifun = pipe_q.ifun;
  assign bus.out_rA = pipe_q.ra;
  assign bus.out_rB = pipe_q.rb;
  assign bus.out_valC = pipe_q.valc;
  assign bus.out_valP = pipe_q.valp;
  assign bus.out_valid = pipe_q.valid;
  assign bus.stall_err = state_q == ERR;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] scnt_q, bcnt_q;
  // saturating event counters, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q <= '0;
      bcnt_q <= '0;
    end else begin
      scnt_q <= (hold_req && !(&scnt_q)) ? scnt_q + 1'b1 : scnt_q;
      bcnt_q <= (bus.bubble && !(&bcnt_q)) ? bcnt_q + 1'b1 : bcnt_q;
    end
  end
  assign stall_cnt = scnt_q;
  assign bubble_cnt = bcnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomized checks of pipe_stage_reg against a behavioural model
module tb_pipe_stage_reg;
  localparam int LIM = 4;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [148:0] BUBV = {3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0, 1'b0};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  pipe_stage_reg_if #(.WORD_W(64), .STAT_W(3)) bus ();
`ifdef PERF_CNT_EN
  logic [CW-1:0] stall_cnt, bubble_cnt;
`endif
  pipe_stage_reg #(.STALL_LIMIT(LIM), .CNT_W(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );
  logic [2:0] m_stat;
  logic [3:0] m_icode, m_ifun, m_ra, m_rb;
  logic [63:0] m_valc, m_valp;
  logic m_valid, m_err;
  int m_streak, m_scnt, m_bcnt;
  function automatic void model_reset();
    {m_stat, m_icode, m_ifun, m_ra, m_rb, m_valc, m_valp, m_valid, m_err} = BUBV;
    m_streak = 0;
    m_scnt = 0;
    m_bcnt = 0;
  endfunction
  function automatic void model_edge();
    bit s;
    s = bus.stall && !bus.bubble;
    if (bus.bubble) begin
      m_stat = 3'd1; m_icode = 4'h1; m_ifun = 4'h0; m_ra = 4'hF; m_rb = 4'hF;
      m_valc = 64'd0; m_valp = 64'd0; m_valid = 1'b0;
    end else if (!bus.stall) begin
      m_stat = bus.in_stat; m_icode = bus.in_icode; m_ifun = bus.in_ifun; m_ra = bus.in_rA;
      m_rb = bus.in_rB; m_valc = bus.in_valC; m_valp = bus.in_valP; m_valid = 1'b1;
    end
    if (m_err) begin
      if (bus.clr_err) begin
        m_err = 1'b0;
        m_streak = s ? 1 : 0;
      end
    end else begin
      m_streak = s ? m_streak + 1 : 0;
      if (m_streak >= LIM) m_err = 1'b1;
    end
    if (s && m_scnt < CMAX) m_scnt++;
    if (bus.bubble && m_bcnt < CMAX) m_bcnt++;
  endfunction
  function automatic logic [148:0] dut_vec();
    return {bus.out_stat, bus.out_icode, bus.out_ifun, bus.out_rA, bus.out_rB,
            bus.out_valC, bus.out_valP, bus.out_valid, bus.stall_err};
  endfunction
  function automatic logic [148:0] exp_vec();
    return {m_stat, m_icode, m_ifun, m_ra, m_rb, m_valc, m_valp, m_valid, m_err};
  endfunction
  task automatic drive(input bit st, input bit bu, input bit cl);
    bus.stall = st;
    bus.bubble = bu;
    bus.clr_err = cl;
    bus.in_stat = 3'($urandom);
    bus.in_icode = 4'($urandom);
    bus.in_ifun = 4'($urandom);
    bus.in_rA = 4'($urandom);
    bus.in_rB = 4'($urandom);
    bus.in_valC = {$urandom, $urandom};
    bus.in_valP = {$urandom, $urandom};
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic test_reset();
    drive(0, 0, 0);
    #12;
    compared++;
    if (dut_vec() !== BUBV) begin
      mismatched++;
      $display("FAIL reset_values: got %h exp %h", dut_vec(), BUBV);
    end
`ifdef PERF_CNT_EN
    compared++;
    if ({stall_cnt, bubble_cnt} !== '0) begin
      mismatched++;
      $display("FAIL reset_counters: got %h/%h exp 0/0", stall_cnt, bubble_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  task automatic test_load();
    drive(0, 0, 0);
    bus.in_icode = 4'h3;
    bus.in_rA = 4'h2;
    bus.in_valC = 64'h10;
    tick();
    compared++;
    if ({bus.out_icode, bus.out_rA, bus.out_valC, bus.out_valid} !== {4'h3, 4'h2, 64'h10, 1'b1}) begin
      mismatched++;
      $display("FAIL load: got icode=%h rA=%h valC=%h valid=%b exp 3 2 10 1",
               bus.out_icode, bus.out_rA, bus.out_valC, bus.out_valid);
    end
    compared++;
    if (dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL load_all: got %h exp %h", dut_vec(), exp_vec());
    end
  endtask
  task automatic test_stall();
    drive(0, 0, 0);
    bus.in_icode = 4'h6;
    tick();
    drive(1, 0, 0);
    bus.in_icode = 4'h9;
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if (bus.out_icode !== 4'h6 || dut_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: got icode=%h vec=%h exp icode=6 vec=%h", i, bus.out_icode, dut_vec(), exp_vec());
      end
    end
  endtask
  task automatic test_bubble_over_stall();
    drive(1, 1, 0);
    tick();
    compared++;
    if (dut_vec() !== BUBV) begin
      mismatched++;
      $display("FAIL bubble_over_stall: got %h exp %h", dut_vec(), BUBV);
    end
  endtask
  task automatic test_watchdog();
    drive(0, 0, 0);
    tick();
    drive(1, 0, 0);
    for (int i = 1; i <= LIM; i++) begin
      tick();
      compared++;
      if (bus.stall_err !== (i == LIM)) begin
        mismatched++;
        $display("FAIL watchdog_edge%0d: got stall_err=%b exp %b", i, bus.stall_err, i == LIM);
      end
    end
    drive(0, 0, 0);
    bus.in_icode = 4'hA;
    tick();
    compared++;
    if ({bus.stall_err, bus.out_valid, bus.out_icode} !== {1'b1, 1'b1, 4'hA}) begin
      mismatched++;
      $display("FAIL err_sticky_load: got err=%b valid=%b icode=%h exp 1 1 a",
               bus.stall_err, bus.out_valid, bus.out_icode);
    end
    drive(0, 0, 1);
    tick();
    compared++;
    if (bus.stall_err !== 1'b0 || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL clr_err: got err=%b vec=%h exp err=0 vec=%h", bus.stall_err, dut_vec(), exp_vec());
    end
  endtask
  task automatic test_mid_stall_reset();
    drive(0, 0, 0);
    tick();
    drive(1, 0, 0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (dut_vec() !== BUBV) begin
      mismatched++;
      $display("FAIL mid_stall_reset: got %h exp %h", dut_vec(), BUBV);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1, 0, 0);
    for (int i = 0; i < LIM - 1; i++) tick();
    compared++;
    if (bus.stall_err !== 1'b0 || dut_vec() !== exp_vec()) begin
      mismatched++;
      $display("FAIL fsm_after_reset: got err=%b vec=%h exp err=0 vec=%h", bus.stall_err, dut_vec(), exp_vec());
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 15);
      tick();
      compared++;
      if (dut_vec() !== exp_vec()) begin
        mismatched++;
        $display("FAIL random[%0d]: got %h exp %h", i, dut_vec(), exp_vec());
      end
`ifdef PERF_CNT_EN
      compared++;
      if (stall_cnt !== CW'(m_scnt) || bubble_cnt !== CW'(m_bcnt)) begin
        mismatched++;
        $display("FAIL perf_cnt[%0d]: got %0d/%0d exp %0d/%0d", i, stall_cnt, bubble_cnt, m_scnt, m_bcnt);
      end
`endif
    end
  endtask
  initial begin
    test_reset();
    test_load();
    test_stall();
    test_bubble_over_stall();
    test_watchdog();
    test_mid_stall_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
